// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Bundles every signal between the ID/EX issue register and its neighbours:
//   the decode-side request (in_*, forwarding values, flush) and the EX-side
//   operand/control response (out_*).
//   master : decode/EX side   - drives requests, forwarding values, flush, out_ready
//   slave  : alu_issue_stage  - drives in_ready and all out_* signals
interface alu_issue_stage_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [2:0]       in_funct3;
    logic             in_funct7b5;
    logic             in_is_rtype;
    logic             in_alusrc;
    logic [1:0]       in_fwd_a;
    logic [1:0]       in_fwd_b;
    logic [WIDTH-1:0] in_rs1_data;
    logic [WIDTH-1:0] in_rs2_data;
    logic [WIDTH-1:0] in_imm;
    logic [WIDTH-1:0] exmem_result;
    logic [WIDTH-1:0] memwb_result;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_ctrl;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_rs2_fwd;
    logic             out_br_on_z;

    modport master (
        output flush, in_valid, in_aluop, in_funct3, in_funct7b5, in_is_rtype,
               in_alusrc, in_fwd_a, in_fwd_b, in_rs1_data, in_rs2_data, in_imm,
               exmem_result, memwb_result, out_ready,
        input  in_ready, out_valid, out_ctrl, out_a, out_b, out_rs2_fwd, out_br_on_z
    );

    modport slave (
        input  flush, in_valid, in_aluop, in_funct3, in_funct7b5, in_is_rtype,
               in_alusrc, in_fwd_a, in_fwd_b, in_rs1_data, in_rs2_data, in_imm,
               exmem_result, memwb_result, out_ready,
        output in_ready, out_valid, out_ctrl, out_a, out_b, out_rs2_fwd, out_br_on_z
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX issue register of the 5-stage RV32I pipeline. Encodes decoded fields
//   into the 4-bit ALU control word, resolves operand forwarding, selects the
//   B operand and registers everything for the ALU. Single-entry valid/ready
//   stage with stall (out_ready=0) and flush.
//   Ports:
//     clk    pipeline clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    alu_issue_stage_if.slave: decode request, forwarding values,
//            flush, and the registered ALU control/operand outputs
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SLL  = 4'b0011;
    localparam logic [3:0] C_SLT  = 4'b0100;
    localparam logic [3:0] C_SLTU = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_XOR  = 4'b0111;
    localparam logic [3:0] C_SRL  = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1010;

    localparam logic [1:0] OP_ADDR  = 2'b00;
    localparam logic [1:0] OP_BRNCH = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_LUI   = 2'b11;

    typedef struct packed {
        logic [3:0]       ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] rs2f;
        logic             brz;
    } entry_t;

    entry_t ent_q, ent_d;
    logic   vld_q;
    logic   capture;

    // 00 and 11 both pick the register file value
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] rf,
                                                 input logic [WIDTH-1:0] exmem,
                                                 input logic [WIDTH-1:0] memwb);
        case (sel)
            2'b01:   fwd_mux = exmem;
            2'b10:   fwd_mux = memwb;
            default: fwd_mux = rf;
        endcase
    endfunction

    // ALU control encoding and branch polarity
    always_comb begin
        ent_d.ctrl = C_ADD;
        ent_d.brz  = 1'b0;
        case (bus.in_aluop)
            OP_BRNCH: begin
                case (bus.in_funct3)
                    3'b100, 3'b101: ent_d.ctrl = C_SLT;
                    3'b110, 3'b111: ent_d.ctrl = C_SLTU;
                    default:        ent_d.ctrl = C_SUB;
                endcase
                // BEQ, BGE, BGEU take the branch on zero; the rest on non-zero
                ent_d.brz = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b101) ||
                            (bus.in_funct3 == 3'b111);
            end
            OP_ARITH: begin
                case (bus.in_funct3)
                    // funct7b5 on an I-type ADDI is immediate bits, not SUB
                    3'b000:  ent_d.ctrl = (bus.in_is_rtype && bus.in_funct7b5) ? C_SUB : C_ADD;
                    3'b001:  ent_d.ctrl = C_SLL;
                    3'b010:  ent_d.ctrl = C_SLT;
                    3'b011:  ent_d.ctrl = C_SLTU;
                    3'b100:  ent_d.ctrl = C_XOR;
                    3'b101:  ent_d.ctrl = bus.in_funct7b5 ? C_SRA : C_SRL;
                    3'b110:  ent_d.ctrl = C_OR;
                    default: ent_d.ctrl = C_AND;
                endcase
            end
            default: ent_d.ctrl = C_ADD;  // address add and LUI
        endcase
    end

    // Operand selection; forwarding values are only looked at in the capture cycle
    always_comb begin
        ent_d.rs2f = fwd_mux(bus.in_fwd_b, bus.in_rs2_data, bus.exmem_result, bus.memwb_result);
        if (bus.in_aluop == OP_LUI) begin
            ent_d.a = '0;
            ent_d.b = bus.in_imm;
        end else begin
            ent_d.a = fwd_mux(bus.in_fwd_a, bus.in_rs1_data, bus.exmem_result, bus.memwb_result);
            ent_d.b = bus.in_alusrc ? bus.in_imm : ent_d.rs2f;
        end
    end

    assign bus.in_ready = !vld_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= 1'b0;
            ent_q.ctrl <= C_ADD;
            ent_q.a    <= '0;
            ent_q.b    <= '0;
            ent_q.rs2f <= '0;
            ent_q.brz  <= 1'b0;
        end else begin
            if (bus.flush)
                vld_q <= 1'b0;
            else if (bus.in_ready)
                vld_q <= bus.in_valid;
            // data outputs keep their last value when the stage drains or flushes
            if (capture)
                ent_q <= ent_d;
        end
    end

    assign bus.out_valid   = vld_q;
    assign bus.out_ctrl    = ent_q.ctrl;
    assign bus.out_a       = ent_q.a;
    assign bus.out_b       = ent_q.b;
    assign bus.out_rs2_fwd = ent_q.rs2f;
    assign bus.out_br_on_z = ent_q.brz;

endmodule
